bcd_display_scan: RTL and testbench

- Consumer end of the BCD counter chain. Takes N_DIGITS packed BCD digits from cascaded counters and drives a common-anode, time-multiplexed seven-segment display.
- Captures a coherent snapshot of all digits once per scan frame, so the display never shows a half-carried value.
- Rotates anodes at a programmable slot rate, with a blanking gap between slots to suppress ghosting.
- Sits between the counter array and the board display pins.

---
 rtl/bcd_display_scan.sv | 143 ++++++++++++++
 tb/tb_bcd_display_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame BCD snapshot.
// Optional leading-zero suppression: define BCD_DISPLAY_LEADING_ZERO_BLANK_EN.
module bcd_display_scan #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned REFRESH_TICKS = 100000,
    parameter int unsigned BLANK_TICKS   = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int unsigned CW = ($clog2(REFRESH_TICKS) < 1) ? 1 : $clog2(REFRESH_TICKS);
    localparam int unsigned IW = ($clog2(N_DIGITS) < 1) ? 1 : $clog2(N_DIGITS);

    localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [IW-1:0] IDX_MAX    = IW'(N_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [0:0]            state_q, state_d;
    logic [4*N_DIGITS-1:0] shadow_q;
    logic [N_DIGITS-1:0]   dpsnap_q;
    logic                  cnt_wrap;
    logic                  snap;

    logic [3:0]            cur_digit;
    logic                  cur_dp;
    logic                  cur_supp;
    logic [N_DIGITS-1:0]   supp;
    logic [N_DIGITS-1:0]   an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        snap = cnt_wrap && (idx_q == IDX_MAX);
        // State goes DRIVE on the edge where cnt becomes BLANK_TICKS.
        if (cnt_wrap) begin
            state_d = ST_BLANK;
        end else if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
        end else begin
            state_d = state_q;
        end
    end

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (shadow_q[4*k +: 4] == 4'd0);
            supp[k]  = zero_run;
        end
    end
`else
    assign supp = '0;
`endif

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_supp  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit = shadow_q[4*k +: 4];
                cur_dp    = dpsnap_q[k];
                cur_supp  = supp[k];
            end
        end
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_q == ST_DRIVE && !cur_supp) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                an_d[k] = (idx_q != IW'(k));
            end
            seg_d = seg7(cur_digit);
            dp_d  = ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= ST_BLANK;
            shadow_q   <= '0;
            dpsnap_q   <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            if (snap) begin
                shadow_q <= digits;
                dpsnap_q <= dp_in;
            end
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_tick <= snap;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan (N=4, REFRESH=8, BLANK=2).
// Expectations follow BCD_DISPLAY_LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_display_scan;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits = 16'h0;
    logic [3:0]    dp_in = 4'h0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    bcd_display_scan #(
        .N_DIGITS      (N),
        .REFRESH_TICKS (R),
        .BLANK_TICKS   (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check_blank(input string tag);
        check({tag, ".an"}, {12'h0, an}, 16'h000F);
        check({tag, ".seg"}, {9'h0, seg}, 16'h007F);
        check({tag, ".dp"}, {15'h0, dp}, 16'h0001);
    endtask

    // Slot k of the frame starting at cycle base: two off cycles, then the lit window.
    task automatic check_slot(input int base, input int k, input logic [6:0] seg_e,
                              input logic dp_e, input bit lit);
        logic [3:0] an_e;
        string      t;
        an_e = lit ? ~(4'b0001 << k) : 4'b1111;
        t = $sformatf("f%0d.s%0d", base / (N * R), k);
        run_to(base + 8 * k + 1);
        check({t, ".off1.an"}, {12'h0, an}, 16'h000F);
        run_to(base + 8 * k + 2);
        check({t, ".off2.an"}, {12'h0, an}, 16'h000F);
        run_to(base + 8 * k + 3);
        check({t, ".an"}, {12'h0, an}, {12'h0, an_e});
        check({t, ".seg"}, {9'h0, seg}, lit ? {9'h0, seg_e} : 16'h007F);
        check({t, ".dp"}, {15'h0, dp}, lit ? {15'h0, dp_e} : 16'h0001);
        run_to(base + 8 * k + 7);
        check({t, ".end.an"}, {12'h0, an}, {12'h0, an_e});
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        digits = 16'h1234;
        dp_in  = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        check_blank("rst");
        check("rst.ft", {15'h0, frame_tick}, 16'h0);

        release_reset();
        check_blank("c0");
        tick();
        check_blank("c1");
        tick();
        check_blank("c2");
        tick();
        check("c3.an", {12'h0, an}, 16'h000E);
        check("c3.seg", {9'h0, seg}, 16'h0040);
        check("c3.dp", {15'h0, dp}, 16'h0001);
        check_slot(0, 1, 7'h40, 1'b1, !LZ);

        run_to(31);
        check("ft.c31", {15'h0, frame_tick}, 16'h0);
        run_to(32);
        check("ft.c32", {15'h0, frame_tick}, 16'h1);
        run_to(33);
        check("ft.c33", {15'h0, frame_tick}, 16'h0);

        // Frame 1: 1234 with dp on digit 2; inputs change mid-frame.
        check_slot(32, 0, 7'h19, 1'b1, 1'b1);
        check_slot(32, 1, 7'h30, 1'b1, 1'b1);
        digits = 16'h0999;
        dp_in  = 4'b0000;
        check_slot(32, 2, 7'h24, 1'b0, 1'b1);
        check_slot(32, 3, 7'h79, 1'b1, 1'b1);

        // Frame 2: 0999.
        run_to(64);
        check("ft.c64", {15'h0, frame_tick}, 16'h1);
        check_slot(64, 0, 7'h10, 1'b1, 1'b1);
        check_slot(64, 1, 7'h10, 1'b1, 1'b1);
        check_slot(64, 2, 7'h10, 1'b1, 1'b1);
        check_slot(64, 3, 7'h40, 1'b1, !LZ);
        digits = 16'h00AF;

        // Frame 3: 00AF -> dashes in digits 0 and 1.
        check_slot(96, 0, 7'h3F, 1'b1, 1'b1);
        check_slot(96, 1, 7'h3F, 1'b1, 1'b1);
        check_slot(96, 2, 7'h40, 1'b1, !LZ);
        check_slot(96, 3, 7'h40, 1'b1, !LZ);

        // Async reset in the middle of slot 2's drive window.
        run_to(128 + 16 + 4);
        check("pre.an", {12'h0, an}, LZ ? 16'h000F : 16'h000B);
        #2;
        rst_n = 1'b0;
        #1;
        check_blank("arst");
        digits = 16'h0050;
        dp_in  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_blank("arst.hold");

        release_reset();
        run_to(3);
        check("r2.c3.an", {12'h0, an}, 16'h000E);
        check("r2.c3.seg", {9'h0, seg}, 16'h0040);
        check_slot(0, 1, 7'h40, 1'b1, !LZ);
        check_slot(0, 2, 7'h40, 1'b1, !LZ);

        // Frame 1 after restart: 0050.
        check_slot(32, 0, 7'h40, 1'b1, 1'b1);
        check_slot(32, 1, 7'h12, 1'b1, 1'b1);
        check_slot(32, 2, 7'h40, 1'b1, !LZ);
        check_slot(32, 3, 7'h40, 1'b1, !LZ);
        digits = 16'h0000;

        // Frame 2: all zero.
        check_slot(64, 0, 7'h40, 1'b1, 1'b1);
        check_slot(64, 1, 7'h40, 1'b1, !LZ);
        check_slot(64, 2, 7'h40, 1'b1, !LZ);
        check_slot(64, 3, 7'h40, 1'b1, !LZ);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
